deinterleaver: RTL and testbench

RX-side data deinterleaver for the 802.11a PHY. It inverts the TX interleaver's two-step permutation over one OFDM symbol of Ncbps coded bits, for Ncbps = 48, 96 and 192 (BPSK, QPSK, 16-QAM). It sits between the RX demapper and the Viterbi decoder. Input arrives serially in interleaved order, and output leaves serially in original coded order, using a ping-pong pair of symbol buffers.

---
 rtl/phy_pkg.sv | 32 +++
 rtl/deint_rd_addr.sv | 59 +++++
 rtl/deinterleaver.sv | 104 ++++++++++
 tb/tb_deinterleaver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared 802.11a PHY definitions: SIGNAL RATE codes and the per-rate
// interleaver geometry used by both the TX interleaver and RX deinterleaver.
package phy_pkg;

  localparam logic [3:0] R_6MBPS  = 4'b1101;
  localparam logic [3:0] R_9MBPS  = 4'b1111;
  localparam logic [3:0] R_12MBPS = 4'b0101;
  localparam logic [3:0] R_18MBPS = 4'b0111;
  localparam logic [3:0] R_24MBPS = 4'b1001;
  localparam logic [3:0] R_36MBPS = 4'b1011;
  localparam logic [3:0] R_48MBPS = 4'b0001;
  localparam logic [3:0] R_54MBPS = 4'b0011;

  // Coded bits per OFDM symbol; unsupported and invalid codes fall back to 48.
  function automatic logic [7:0] rate_to_ncbps(input logic [3:0] rate);
    case (rate)
      R_12MBPS, R_18MBPS: rate_to_ncbps = 8'd96;
      R_24MBPS, R_36MBPS: rate_to_ncbps = 8'd192;
      default:            rate_to_ncbps = 8'd48;
    endcase
  endfunction

  // Interleaver row count Ncbps/16.
  function automatic logic [3:0] rate_to_ni(input logic [3:0] rate);
    case (rate)
      R_12MBPS, R_18MBPS: rate_to_ni = 4'd6;
      R_24MBPS, R_36MBPS: rate_to_ni = 4'd12;
      default:            rate_to_ni = 4'd3;
    endcase
  endfunction

endpackage

// File: rtl/deint_rd_addr.sv
// Read-address generator for the deinterleaver: walks output index
// k = 16*row + col and maps it to the interleaved buffer position.
module deint_rd_addr
  import phy_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [3:0] rate_i,
  output logic [7:0] rd_addr_c,
  output logic       eos_c,
  output logic       k0_c
);

  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [3:0] ni_c;
  logic [3:0] off_c;

  // 16-QAM swaps bit pairs on odd columns, which toggles the row LSB.
  always_comb begin
    ni_c      = rate_to_ni(rate_i);
    off_c     = row_q;
    if ((ni_c == 4'd12) && col_q[0]) begin
      off_c = row_q ^ 4'd1;
    end
    rd_addr_c = 8'(ni_c) * 8'(col_q) + 8'(off_c);
    eos_c     = (col_q == 4'd15) && (row_q == ni_c - 4'd1);
    k0_c      = (col_q == 4'd0) && (row_q == 4'd0);
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = 4'd0;
      col_d = 4'd0;
    end else if (en_i) begin
      if (col_q == 4'd15) begin
        col_d = 4'd0;
        row_d = eos_c ? 4'd0 : row_q + 4'd1;
      end else begin
        col_d = col_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= 4'd0;
      col_q <= 4'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/deinterleaver.sv
// 802.11a RX deinterleaver: ping-pong symbol banks, one bank filled in
// interleaved order while the other is read back in coded order.
module deinterleaver
  import phy_pkg::*;
#(
  parameter int unsigned DW   = 1,
  parameter int unsigned NMAX = 192
) (
  input  logic          iClk,
  input  logic          iRstN,
  input  logic          iEN,
  input  logic          iRateEN,
  input  logic [3:0]    iRate,
  input  logic [DW-1:0] iData,
  output logic [DW-1:0] oData,
  output logic          oValid,
  output logic          oBlkStart
);

  localparam int unsigned AW = 8;

  logic [DW-1:0] bank_q [2][NMAX];
  logic [3:0]    rate_q;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          sel_q, sel_d;
  logic          out_en_q, out_en_d;
  logic          adv_c;
  logic [AW-1:0] rd_addr_c;
  logic          eos_c;
  logic          k0_c;

  assign adv_c = iEN & ~iRateEN;

  deint_rd_addr u_rd_addr (
    .clk_i     (iClk),
    .rst_ni    (iRstN),
    .en_i      (adv_c),
    .clr_i     (iRateEN),
    .rate_i    (rate_q),
    .rd_addr_c (rd_addr_c),
    .eos_c     (eos_c),
    .k0_c      (k0_c)
  );

  // Read and write counters advance together, so the read side's
  // end-of-symbol also marks the write wrap and the bank swap.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    sel_d    = sel_q;
    out_en_d = out_en_q;
    if (iRateEN) begin
      wr_cnt_d = '0;
      sel_d    = 1'b0;
      out_en_d = 1'b0;
    end else if (iEN) begin
      if (eos_c) begin
        wr_cnt_d = '0;
        sel_d    = ~sel_q;
        out_en_d = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      rate_q   <= R_6MBPS;
      wr_cnt_q <= '0;
      sel_q    <= 1'b0;
      out_en_q <= 1'b0;
    end else begin
      if (iRateEN) begin
        rate_q <= iRate;
      end
      wr_cnt_q <= wr_cnt_d;
      sel_q    <= sel_d;
      out_en_q <= out_en_d;
    end
  end

  // Symbol storage carries no reset.
  always_ff @(posedge iClk) begin
    if (adv_c) begin
      bank_q[sel_q][wr_cnt_q] <= iData;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oData     <= '0;
      oValid    <= 1'b0;
      oBlkStart <= 1'b0;
    end else if (adv_c) begin
      oData     <= bank_q[~sel_q][rd_addr_c];
      oValid    <= out_en_q;
      oBlkStart <= out_en_q & k0_c;
    end else begin
      oValid    <= 1'b0;
      oBlkStart <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deinterleaver.sv
// Directed self-checking bench for the 802.11a deinterleaver (4-bit soft samples).
module tb_deinterleaver;
  import phy_pkg::*;

  localparam int DW = 4;

  logic          iClk = 1'b0;
  logic          iRstN;
  logic          iEN;
  logic          iRateEN;
  logic [3:0]    iRate;
  logic [DW-1:0] iData;
  logic [DW-1:0] oData;
  logic          oValid;
  logic          oBlkStart;

  deinterleaver #(.DW(DW), .NMAX(192)) dut (
    .iClk      (iClk),
    .iRstN     (iRstN),
    .iEN       (iEN),
    .iRateEN   (iRateEN),
    .iRate     (iRate),
    .iData     (iData),
    .oData     (oData),
    .oValid    (oValid),
    .oBlkStart (oBlkStart)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  logic [DW-1:0] out_q[$];
  logic          bs_q[$];
  logic [DW-1:0] orig_q[$];
  logic [DW-1:0] stim[192];
  bit            seen_valid = 1'b0;
  int            first_valid_cyc = 0;
  logic [8:0]    prbs = 9'h1FF;

  always @(negedge iClk) begin
    if (oValid === 1'b1) begin
      out_q.push_back(oData);
      bs_q.push_back(oBlkStart);
      if (!seen_valid) begin
        seen_valid      = 1'b1;
        first_valid_cyc = cyc;
      end
    end
  end

  // Reference TX interleaver position of coded bit k.
  function automatic int tx_pos(input int k, input int n);
    int s, i;
    s = (n == 192) ? 2 : 1;
    i = (n / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + n - (16 * i) / n) % s;
  endfunction

  function automatic logic [DW-1:0] prbs_sample();
    logic [DW-1:0] v;
    for (int b = 0; b < DW; b++) begin
      v[b] = prbs[8] ^ prbs[4];
      prbs = {prbs[7:0], v[b]};
    end
    return v;
  endfunction

  task automatic clear_mon();
    out_q.delete();
    bs_q.delete();
    seen_valid = 1'b0;
  endtask

  task automatic drive(input logic [DW-1:0] d);
    @(negedge iClk);
    iEN     = 1'b1;
    iRateEN = 1'b0;
    iData   = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iClk);
      iEN     = 1'b0;
      iRateEN = 1'b0;
      iData   = '0;
    end
  endtask

  task automatic load_rate(input logic [3:0] r);
    @(negedge iClk);
    iEN     = 1'b0;
    iRateEN = 1'b1;
    iRate   = r;
    @(negedge iClk);
    iRateEN = 1'b0;
    clear_mon();
  endtask

  // Interleave one symbol taken from orig_q starting at base into stim.
  task automatic build_sym(input int base, input int n);
    for (int k = 0; k < n; k++) stim[tx_pos(k, n)] = orig_q[base + k];
  endtask

  task automatic test_reset();
    iRstN = 1'b0; iEN = 1'b0; iRateEN = 1'b0; iRate = 4'd0; iData = '0;
    #12;
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", oValid); end
    checks++; if (oBlkStart !== 1'b0) begin errors++; $display("FAIL reset_blkstart: got %b expected 0", oBlkStart); end
    checks++; if (oData !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", oData); end
    @(negedge iClk);
    iRstN = 1'b1;
    idle(2);
  endtask

  task automatic test_onehot_6();
    int t0, bad, badbs;
    load_rate(R_6MBPS);
    t0 = 0;
    for (int j = 0; j < 48; j++) begin
      drive((j == 1) ? 4'hA : 4'h0);
      if (j == 0) t0 = cyc;
    end
    for (int j = 0; j < 48; j++) drive(4'h0);
    idle(3);
    checks++; if (out_q.size() != 48) begin errors++; $display("FAIL onehot6_count: got %0d expected 48", out_q.size()); end
    checks++; if (out_q.size() < 17 || out_q[16] !== 4'hA) begin errors++; $display("FAIL onehot6_k16: got %h expected a", (out_q.size() > 16) ? out_q[16] : 4'hx); end
    bad = 0; badbs = 0;
    for (int k = 0; k < out_q.size(); k++) begin
      if (k != 16 && out_q[k] !== 4'h0) bad++;
      if (bs_q[k] !== (k == 0)) badbs++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL onehot6_others: got %0d nonzero expected 0", bad); end
    checks++; if (badbs != 0) begin errors++; $display("FAIL onehot6_blkstart: got %0d misplaced expected 0", badbs); end
    checks++; if (first_valid_cyc - t0 != 49) begin errors++; $display("FAIL onehot6_latency: got %0d expected 49", first_valid_cyc - t0); end
  endtask

  task automatic test_onehot_24();
    int bad;
    load_rate(R_24MBPS);
    for (int j = 0; j < 192; j++) drive((j == 13) ? 4'h5 : 4'h0);
    for (int j = 0; j < 192; j++) drive((j == 1) ? 4'h9 : 4'h0);
    for (int j = 0; j < 192; j++) drive(4'h0);
    idle(3);
    checks++; if (out_q.size() != 384) begin errors++; $display("FAIL onehot24_count: got %0d expected 384", out_q.size()); end
    checks++; if (out_q.size() < 2 || out_q[1] !== 4'h5) begin errors++; $display("FAIL onehot24_k1: got %h expected 5", (out_q.size() > 1) ? out_q[1] : 4'hx); end
    checks++; if (out_q.size() < 209 || out_q[192 + 16] !== 4'h9) begin errors++; $display("FAIL onehot24_k16: got %h expected 9", (out_q.size() > 208) ? out_q[208] : 4'hx); end
    bad = 0;
    for (int k = 0; k < out_q.size(); k++) if (k != 1 && k != 208 && out_q[k] !== 4'h0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL onehot24_others: got %0d nonzero expected 0", bad); end
  endtask

  // Sends nsym PRBS symbols plus pad zero symbols, optionally with random stalls.
  task automatic run_stream(input string name, input logic [3:0] r, input int n,
                            input int nsym, input int pad, input int duty);
    int exp_cnt, bad, badbs, guard;
    orig_q.delete();
    for (int i = 0; i < nsym * n; i++) orig_q.push_back(prbs_sample());
    for (int i = 0; i < pad * n; i++) orig_q.push_back('0);
    load_rate(r);
    for (int s = 0; s < nsym + pad; s++) begin
      build_sym(s * n, n);
      for (int j = 0; j < n; j++) begin
        guard = 0;
        while (duty < 100 && $urandom_range(99) >= duty && guard < 20) begin
          idle(1);
          guard++;
        end
        drive(stim[j]);
      end
    end
    idle(3);
    exp_cnt = (nsym + pad - 1) * n;
    checks++; if (out_q.size() != exp_cnt) begin errors++; $display("FAIL %s_count: got %0d expected %0d", name, out_q.size(), exp_cnt); end
    bad = 0; badbs = 0;
    for (int k = 0; k < out_q.size() && k < exp_cnt; k++) begin
      if (out_q[k] !== orig_q[k]) bad++;
      if (bs_q[k] !== ((k % n) == 0)) badbs++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL %s_data: got %0d wrong samples expected 0", name, bad); end
    checks++; if (badbs != 0) begin errors++; $display("FAIL %s_blkstart: got %0d misplaced expected 0", name, badbs); end
  endtask

  task automatic test_round_trip();
    run_stream("rt6", R_6MBPS, 48, 6, 1, 100);
    run_stream("rt12", R_18MBPS, 96, 6, 1, 100);
    run_stream("rt24", R_36MBPS, 192, 6, 1, 100);
  endtask

  task automatic test_stalls();
    run_stream("stall12", R_12MBPS, 96, 4, 0, 30);
  endtask

  task automatic test_rate_switch();
    int bad;
    load_rate(R_6MBPS);
    for (int j = 0; j < 68; j++) drive(4'h7);
    @(negedge iClk);
    iRateEN = 1'b1; iRate = R_24MBPS; iEN = 1'b1; iData = 4'hF;
    @(negedge iClk);
    iRateEN = 1'b0; iEN = 1'b0;
    clear_mon();
    orig_q.delete();
    for (int i = 0; i < 192; i++) orig_q.push_back(prbs_sample());
    build_sym(0, 192);
    for (int j = 0; j < 192; j++) drive(stim[j]);
    idle(1);
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL switch_quiet: got %0d valid expected 0", out_q.size()); end
    for (int j = 0; j < 192; j++) drive(4'h0);
    idle(3);
    checks++; if (out_q.size() != 192) begin errors++; $display("FAIL switch_count: got %0d expected 192", out_q.size()); end
    bad = 0;
    for (int k = 0; k < out_q.size() && k < 192; k++) if (out_q[k] !== orig_q[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL switch_data: got %0d wrong samples expected 0", bad); end
  endtask

  task automatic test_async_reset();
    int bad;
    load_rate(R_6MBPS);
    for (int j = 0; j < 58; j++) drive(4'hF);
    @(posedge iClk);
    #2;
    checks++; if (oValid !== 1'b1 || oData !== 4'hF) begin errors++; $display("FAIL areset_pre: got valid %b data %h expected 1 f", oValid, oData); end
    iRstN = 1'b0;
    #1;
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", oValid); end
    checks++; if (oBlkStart !== 1'b0) begin errors++; $display("FAIL areset_blkstart: got %b expected 0", oBlkStart); end
    checks++; if (oData !== '0) begin errors++; $display("FAIL areset_data: got %h expected 0", oData); end
    @(negedge iClk);
    iEN = 1'b0; iRateEN = 1'b0; iRate = R_24MBPS;
    @(negedge iClk);
    iRstN = 1'b1;
    clear_mon();
    for (int j = 0; j < 48; j++) drive((j == 1) ? 4'h6 : 4'h0);
    for (int j = 0; j < 48; j++) drive(4'h0);
    idle(3);
    bad = 0;
    for (int k = 0; k < out_q.size(); k++) if (out_q[k] !== ((k == 16) ? 4'h6 : 4'h0)) bad++;
    checks++; if (out_q.size() != 48 || bad != 0) begin errors++; $display("FAIL areset_resume: got %0d samples %0d wrong expected 48 0", out_q.size(), bad); end
  endtask

  initial begin
    test_reset();
    test_onehot_6();
    test_onehot_24();
    test_round_trip();
    test_stalls();
    test_rate_switch();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
